// File: rtl/result_ascii_pkg.sv
// Shared types and constants for the result-to-ASCII transmit sequencer.
// RESULT_CRLF_EN appends CR LF to every frame.
package result_ascii_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

`ifdef RESULT_CRLF_EN
    localparam int FRAME_LEN = 4;
`else
    localparam int FRAME_LEN = 2;
`endif

    localparam logic [1:0] LAST_IDX = 2'(FRAME_LEN - 1);

endpackage

// File: rtl/result_ascii_tx_if.sv
// Result handshake and uart_tx byte channel bundled for result_ascii_tx.
interface result_ascii_tx_if;
    logic       i_Res_Valid;
    logic [4:0] i_Res_Data;
    logic       o_Res_Ready;
    logic       o_Tx_DV;
    logic [7:0] o_Tx_Byte;
    logic       i_Tx_Done;
    logic       o_Busy;
    logic       o_Timeout;

    modport master (
        output i_Res_Valid, i_Res_Data, i_Tx_Done,
        input  o_Res_Ready, o_Tx_DV, o_Tx_Byte, o_Busy, o_Timeout
    );

    modport slave (
        input  i_Res_Valid, i_Res_Data, i_Tx_Done,
        output o_Res_Ready, o_Tx_DV, o_Tx_Byte, o_Busy, o_Timeout
    );
endinterface

// File: rtl/hex_to_ascii.sv
// Combinational nibble to uppercase ASCII hex digit.
module hex_to_ascii
    import result_ascii_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = ASCII_0 + {4'b0000, nibble};
        if (nibble > 4'd9)
            ascii = ASCII_A + {4'b0000, nibble} - 8'd10;
    end

endmodule

// File: rtl/result_ascii_tx.sv
// Converts a 5-bit adder result to ASCII hex (optionally + CR LF under
// RESULT_CRLF_EN) and paces the bytes into uart_tx with a stall watchdog.
module result_ascii_tx
    import result_ascii_pkg::*;
#(
    parameter int TX_TIMEOUT = 200000
) (
    input  logic             Clock,
    input  logic             Reset,
    result_ascii_tx_if.slave bus
);

    localparam int             WD_W    = $clog2(TX_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TX_TIMEOUT - 2);

    state_t          state;
    logic [1:0]      idx;
    logic [WD_W-1:0] wd;
    logic [4:0]      res_q;
    logic            tx_dv;
    logic [7:0]      tx_byte;
    logic            tmo;

    logic [4:0]      src;
    logic [1:0]      sel;
    logic [1:0][3:0] nib;
    logic [1:0][7:0] digit;
    logic [7:0]      next_byte;

    // In IDLE the first byte is loaded on the capture edge, so it must
    // come straight from the input rather than the not-yet-written register.
    assign src = (state == IDLE) ? bus.i_Res_Data : res_q;
    assign sel = (state == IDLE) ? 2'd0 : idx;
    assign nib = {src[3:0], {3'b000, src[4]}};

    for (genvar g = 0; g < 2; g++) begin : g_dig
        hex_to_ascii u_hex (
            .nibble (nib[g]),
            .ascii  (digit[g])
        );
    end

    always_comb begin
        next_byte = digit[0];
        case (sel)
            2'd0:    next_byte = digit[0];
            2'd1:    next_byte = digit[1];
            2'd2:    next_byte = ASCII_CR;
            default: next_byte = ASCII_LF;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            idx     <= 2'd0;
            wd      <= '0;
            res_q   <= 5'd0;
            tx_dv   <= 1'b0;
            tx_byte <= 8'h00;
            tmo     <= 1'b0;
        end else begin
            tx_dv <= 1'b0;
            tmo   <= 1'b0;
            case (state)
                IDLE: if (bus.i_Res_Valid) begin
                    res_q   <= bus.i_Res_Data;
                    idx     <= 2'd0;
                    tx_dv   <= 1'b1;
                    tx_byte <= next_byte;
                    state   <= SEND;
                end
                SEND: begin
                    wd    <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the final watchdog cycle beats the timeout.
                    if (bus.i_Tx_Done) begin
                        if (idx == LAST_IDX) begin
                            state <= IDLE;
                        end else begin
                            idx   <= idx + 2'd1;
                            state <= GAP;
                        end
                    end else if (wd == WD_LAST) begin
                        tmo   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                default: begin
                    tx_dv   <= 1'b1;
                    tx_byte <= next_byte;
                    state   <= SEND;
                end
            endcase
        end
    end

    assign bus.o_Res_Ready = (state == IDLE);
    assign bus.o_Busy      = (state != IDLE);
    assign bus.o_Tx_DV     = tx_dv;
    assign bus.o_Tx_Byte   = tx_byte;
    assign bus.o_Timeout   = tmo;

endmodule

// File: tb/tb_result_ascii_tx.sv
// Directed bench for result_ascii_tx with a cycle-timed reference model.
module tb_result_ascii_tx;

    localparam int TMO   = 16;
    localparam int DELAY = 3;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    result_ascii_tx_if bus();

    result_ascii_tx #(.TX_TIMEOUT(TMO)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // uart_tx stand-in: done DELAY cycles after each DV, plus injected strays
    bit resp_en = 1'b1;
    bit stray   = 1'b0;
    int done_at = -100;
    always @(negedge Clock)
        if (Reset && bus.o_Tx_DV && resp_en) done_at = cyc + DELAY;
    always @(posedge Clock) begin
        #2;
        bus.i_Tx_Done = (cyc == done_at) || stray;
    end

    // Reference model: remaining bytes of the frame and the cycle of the next DV
    bit         m_active   = 1'b0;
    logic [7:0] m_q[$];
    int         m_dv_cyc   = -100;
    int         m_tmo_cyc  = -100;
    logic [7:0] dv_log[$];
    int         dv_cyc_log[$];
    int         tmo_log[$];

    function automatic void mk_frame(input logic [4:0] d);
        int n;
        n = int'(d[3:0]);
        m_q.delete();
        m_q.push_back(8'h30 + 8'(d[4]));
        m_q.push_back(n <= 9 ? 8'(8'h30 + n) : 8'(8'h41 + n - 10));
`ifdef RESULT_CRLF_EN
        m_q.push_back(8'h0D);
        m_q.push_back(8'h0A);
`endif
    endfunction

    always @(negedge Clock) begin
        bit rdy;
        if (!Reset) begin
            m_active = 1'b0;
            m_q.delete();
            chk("rst_ready", bus.o_Res_Ready, 1);
            chk("rst_busy", bus.o_Busy, 0);
            chk("rst_dv", bus.o_Tx_DV, 0);
            chk("rst_byte", bus.o_Tx_Byte, 8'h00);
            chk("rst_timeout", bus.o_Timeout, 0);
        end else begin
            rdy = !m_active;
            chk("ready", bus.o_Res_Ready, rdy);
            chk("busy", bus.o_Busy, m_active);
            chk("dv", bus.o_Tx_DV, m_active && cyc == m_dv_cyc);
            chk("timeout", bus.o_Timeout, cyc == m_tmo_cyc);
            if (m_active && cyc >= m_dv_cyc) chk("byte", bus.o_Tx_Byte, m_q[0]);
            if (bus.o_Tx_DV) begin
                dv_log.push_back(bus.o_Tx_Byte);
                dv_cyc_log.push_back(cyc);
            end
            if (bus.o_Timeout) tmo_log.push_back(cyc);
            if (m_active && cyc > m_dv_cyc) begin
                if (bus.i_Tx_Done) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_active = 1'b0;
                    else m_dv_cyc = cyc + 2;
                end else if (cyc == m_dv_cyc + TMO - 1) begin
                    m_tmo_cyc = cyc + 1;
                    m_active  = 1'b0;
                    m_q.delete();
                end
            end
            if (rdy && bus.i_Res_Valid) begin
                m_active = 1'b1;
                mk_frame(bus.i_Res_Data);
                m_dv_cyc = cyc + 1;
            end
        end
    end

    logic [7:0] exp_q[$];

    task automatic add_lit(input logic [7:0] hi, input logic [7:0] lo);
        exp_q.push_back(hi);
        exp_q.push_back(lo);
`ifdef RESULT_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    task automatic expect_bytes(input string name);
        chk({name, "_count"}, dv_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < dv_log.size(); i++)
            chk({name, "_byte"}, dv_log[i], exp_q[i]);
    endtask

    task automatic clear_logs();
        dv_log.delete();
        dv_cyc_log.delete();
        tmo_log.delete();
        exp_q.delete();
    endtask

    task automatic send(input logic [4:0] d);
        @(posedge Clock); #1;
        bus.i_Res_Valid = 1'b1;
        bus.i_Res_Data  = d;
        @(posedge Clock); #1;
        bus.i_Res_Valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clock);
            if (!bus.o_Busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_idle_wait"}, ok, 1);
    endtask

    initial begin
        bit ok;
        bus.i_Res_Valid = 1'b0;
        bus.i_Res_Data  = 5'd0;
        bus.i_Tx_Done   = 1'b0;
        repeat (3) @(posedge Clock);
        #1 Reset = 1'b1;

        // 0x1F -> "1F", spacing DV-to-DV = DELAY + 2
        clear_logs();
        send(5'h1F);
        wait_idle("f1f");
        add_lit(8'h31, 8'h46);
        expect_bytes("f1f");
        if (dv_cyc_log.size() >= 2) chk("f1f_dv_spacing", dv_cyc_log[1] - dv_cyc_log[0], DELAY + 2);
        chk("f1f_ready_after", bus.o_Res_Ready, 1);

        // 0x09 -> "09"
        clear_logs();
        send(5'h09);
        wait_idle("f09");
        add_lit(8'h30, 8'h39);
        expect_bytes("f09");
        chk("f09_busy_after", bus.o_Busy, 0);

        // valid held with 0x0A during a frame, captured only once IDLE
        clear_logs();
        @(posedge Clock); #1;
        bus.i_Res_Valid = 1'b1;
        bus.i_Res_Data  = 5'h15;
        @(posedge Clock); #1;
        bus.i_Res_Data  = 5'h0A;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clock);
            if (bus.o_Res_Ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("held_ready_wait", ok, 1);
        @(posedge Clock); #1;
        bus.i_Res_Valid = 1'b0;
        wait_idle("held");
        add_lit(8'h31, 8'h35);
        add_lit(8'h30, 8'h41);
        expect_bytes("held");

        // no done ever: timeout TMO cycles after the DV, nothing further sent
        clear_logs();
        resp_en = 1'b0;
        send(5'h03);
        wait_idle("tmo");
        repeat (10) @(negedge Clock);
        chk("tmo_pulses", tmo_log.size(), 1);
        if (tmo_log.size() >= 1 && dv_cyc_log.size() >= 1)
            chk("tmo_latency", tmo_log[0] - dv_cyc_log[0], TMO);
        chk("tmo_dv_count", dv_cyc_log.size(), 1);
        chk("tmo_ready", bus.o_Res_Ready, 1);
        resp_en = 1'b1;

        // reset during WAIT of byte 1, then a stray done from the old byte
        clear_logs();
        send(5'h1F);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clock); #1;
            if (dv_log.size() == 2) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rstmid_reach_b1", ok, 1);
        @(posedge Clock); #1;
        Reset = 1'b0;
        #1;
        chk("rstmid_async_busy", bus.o_Busy, 0);
        chk("rstmid_async_ready", bus.o_Res_Ready, 1);
        chk("rstmid_async_byte", bus.o_Tx_Byte, 8'h00);
        chk("rstmid_async_dv", bus.o_Tx_DV, 0);
        @(posedge Clock); #1;
        Reset = 1'b1;
        repeat (10) @(negedge Clock);
        chk("rstmid_no_dv", dv_log.size(), 2);

        // stray done in IDLE
        clear_logs();
        @(posedge Clock); #1;
        stray = 1'b1;
        @(posedge Clock); #1;
        stray = 1'b0;
        repeat (5) @(negedge Clock);
        chk("stray_no_dv", dv_log.size(), 0);
        chk("stray_busy", bus.o_Busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, limit 200000 ns");
        $fatal(1, "bench time limit");
    end

endmodule
